// File: rtl/systolic_skew_feeder.sv
// Operand feeder for a ROW x COL systolic array: buffers K beats of A columns / B rows,
// then replays them onto the west/north edges with lane i delayed by i cycles.
module systolic_skew_feeder #(
    parameter int unsigned ROW = 8,
    parameter int unsigned COL = 8,
    parameter int unsigned ES  = 8,
    parameter int unsigned K   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ROW*ES-1:0]   in_a,
    input  logic [COL*ES-1:0]   in_b,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic [ROW*ES-1:0]   a_out,
    output logic [ROW-1:0]      a_out_vld,
    output logic [COL*ES-1:0]   b_out,
    output logic [COL-1:0]      b_out_vld,
    output logic                busy,
    output logic                done
);

    localparam int unsigned M  = (ROW > COL) ? ROW : COL;
    localparam int unsigned L  = K + M - 1;
    localparam int unsigned CW = $clog2(K + M);
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     ld_cnt;
    logic [CW-1:0]     t;

    logic [ROW*ES-1:0] buf_a [K];
    logic [COL*ES-1:0] buf_b [K];

    logic [ROW*ES-1:0] a_nxt;
    logic [ROW-1:0]    a_vld_nxt;
    logic [COL*ES-1:0] b_nxt;
    logic [COL-1:0]    b_vld_nxt;

    assign in_rdy = (state == LOAD);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // Operand storage carries no reset; its contents only matter once fully loaded.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_vld) begin
            buf_a[ld_cnt[KW-1:0]] <= in_a;
            buf_b[ld_cnt[KW-1:0]] <= in_b;
        end
    end

    always_comb begin
        int unsigned tt;
        tt        = 32'(t);
        a_nxt     = '0;
        a_vld_nxt = '0;
        b_nxt     = '0;
        b_vld_nxt = '0;
        if (state == STREAM) begin
            for (int unsigned r = 0; r < ROW; r++) begin
                if (tt >= r && tt <= r + K - 1) begin
                    a_nxt[r*ES +: ES] = buf_a[KW'(tt - r)][r*ES +: ES];
                    a_vld_nxt[r]      = 1'b1;
                end
            end
            for (int unsigned c = 0; c < COL; c++) begin
                if (tt >= c && tt <= c + K - 1) begin
                    b_nxt[c*ES +: ES] = buf_b[KW'(tt - c)][c*ES +: ES];
                    b_vld_nxt[c]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            t         <= '0;
            a_out     <= '0;
            a_out_vld <= '0;
            b_out     <= '0;
            b_out_vld <= '0;
        end else begin
            a_out     <= a_nxt;
            a_out_vld <= a_vld_nxt;
            b_out     <= b_nxt;
            b_out_vld <= b_vld_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        ld_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (in_vld) begin
                        ld_cnt <= ld_cnt + CW'(1);
                        if (ld_cnt == CW'(K - 1)) begin
                            state <= STREAM;
                            t     <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (t == CW'(L - 1)) begin
                        state <= DONE;
                    end else begin
                        t <= t + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder across three array shapes sharing one stimulus path.
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_vld;
    logic [63:0] in_a;
    logic [63:0] in_b;
    int          sel;
    int          cfg_row, cfg_col, cfg_k;

    logic [63:0] d0_a, d0_b;
    logic [7:0]  d0_av, d0_bv;
    logic        d0_rdy, d0_busy, d0_done;
    logic [15:0] d1_a, d1_b;
    logic [1:0]  d1_av, d1_bv;
    logic        d1_rdy, d1_busy, d1_done;
    logic [31:0] d2_a;
    logic [15:0] d2_b;
    logic [3:0]  d2_av;
    logic [1:0]  d2_bv;
    logic        d2_rdy, d2_busy, d2_done;

    logic [63:0] m_a, m_b;
    logic [7:0]  m_av, m_bv;
    logic        m_rdy, m_busy, m_done;

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  av;
        logic [63:0] b;
        logic [7:0]  bv;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int unsigned ba[8][8];
    int unsigned bb[8][8];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          done_before, done_cyc, last_a, last_b;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.ROW(8), .COL(8), .ES(8), .K(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .in_a(in_a), .in_b(in_b),
        .in_vld(in_vld), .in_rdy(d0_rdy), .a_out(d0_a), .a_out_vld(d0_av), .b_out(d0_b),
        .b_out_vld(d0_bv), .busy(d0_busy), .done(d0_done));

    systolic_skew_feeder #(.ROW(2), .COL(2), .ES(8), .K(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .in_a(in_a[15:0]), .in_b(in_b[15:0]),
        .in_vld(in_vld), .in_rdy(d1_rdy), .a_out(d1_a), .a_out_vld(d1_av), .b_out(d1_b),
        .b_out_vld(d1_bv), .busy(d1_busy), .done(d1_done));

    systolic_skew_feeder #(.ROW(4), .COL(2), .ES(8), .K(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .in_a(in_a[31:0]), .in_b(in_b[15:0]),
        .in_vld(in_vld), .in_rdy(d2_rdy), .a_out(d2_a), .a_out_vld(d2_av), .b_out(d2_b),
        .b_out_vld(d2_bv), .busy(d2_busy), .done(d2_done));

    always_comb begin
        m_a = '0; m_b = '0; m_av = '0; m_bv = '0;
        m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        case (sel)
            0: begin
                m_a = d0_a; m_b = d0_b; m_av = d0_av; m_bv = d0_bv;
                m_rdy = d0_rdy; m_busy = d0_busy; m_done = d0_done;
            end
            1: begin
                m_a[15:0] = d1_a; m_b[15:0] = d1_b; m_av[1:0] = d1_av; m_bv[1:0] = d1_bv;
                m_rdy = d1_rdy; m_busy = d1_busy; m_done = d1_done;
            end
            default: begin
                m_a[31:0] = d2_a; m_b[15:0] = d2_b; m_av[3:0] = d2_av; m_bv[1:0] = d2_bv;
                m_rdy = d2_rdy; m_busy = d2_busy; m_done = d2_done;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic set_cfg(input int s);
        sel = s;
        case (s)
            0:       begin cfg_row = 8; cfg_col = 8; cfg_k = 8; end
            1:       begin cfg_row = 2; cfg_col = 2; cfg_k = 3; end
            default: begin cfg_row = 4; cfg_col = 2; cfg_k = 2; end
        endcase
    endtask

    // Monitor: any non-zero output must match the next expected edge snapshot.
    always @(negedge clk) begin
        cyc++;
        if (|{m_a, m_av, m_b, m_bv, m_done}) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {m_av, m_bv} | m_a | m_b | 64'(m_done), 64'd0);
            end else begin
                me = sb.pop_front();
                check("a_out", m_a, me.a);
                check("a_out_vld", 64'(m_av), 64'(me.av));
                check("b_out", m_b, me.b);
                check("b_out_vld", 64'(m_bv), 64'(me.bv));
                check("done", 64'(m_done), 64'(me.done));
            end
            if (m_av[cfg_row-1]) last_a = cyc;
            if (m_bv[cfg_col-1]) last_b = cyc;
            if (m_done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // Start a tile, feed K beats, and queue the edge trace the array must see.
    task automatic load_tile(input int stall_after, input int stall_len, input bit extra, input bit directed);
        int unsigned v;
        int mm, ll;
        exp_t e;
        last_a = -1; last_b = -1; done_cyc = -1;
        done_before = done_seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = extra;
        check("busy_load", 64'(m_busy), 64'd1);
        for (int n = 0; n < cfg_k; n++) begin
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            for (int r = 0; r < cfg_row; r++) begin
                v = directed ? 32'(2*n + r + 1) : $urandom_range(0, 255);
                in_a[r*8 +: 8] = v[7:0];
                ba[n][r] = v;
            end
            for (int c = 0; c < cfg_col; c++) begin
                v = directed ? 32'(7 + 2*n + c) : $urandom_range(0, 255);
                in_b[c*8 +: 8] = v[7:0];
                bb[n][c] = v;
            end
            in_vld = 1'b1;
            check("rdy_load", 64'(m_rdy), 64'd1);
            @(posedge clk); #1;
            if (n == stall_after && n < cfg_k - 1) begin
                in_vld = 1'b0;
                repeat (stall_len) begin
                    check("rdy_stall", 64'(m_rdy), 64'd1);
                    @(posedge clk); #1;
                end
            end
        end
        in_vld = 1'b0;
        mm = (cfg_row > cfg_col) ? cfg_row : cfg_col;
        ll = cfg_k + mm - 1;
        for (int j = 1; j <= ll; j++) begin
            e = '0;
            for (int r = 0; r < cfg_row; r++)
                if (j - 1 >= r && j - 1 <= r + cfg_k - 1) begin
                    e.av[r] = 1'b1;
                    e.a[r*8 +: 8] = ba[j-1-r][r][7:0];
                end
            for (int c = 0; c < cfg_col; c++)
                if (j - 1 >= c && j - 1 <= c + cfg_k - 1) begin
                    e.bv[c] = 1'b1;
                    e.b[c*8 +: 8] = bb[j-1-c][c][7:0];
                end
            e.done = (j == ll);
            sb.push_back(e);
        end
    endtask

    task automatic finish_tile(input bit extra);
        start = extra;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_done) break;
        end
        check("done_reached", 64'(m_done), 64'd1);
        check("busy_done", 64'(m_busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after", 64'(m_busy), 64'd0);
        check("rdy_after", 64'(m_rdy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("one_done", 64'(done_seen), 64'(done_before + 1));
        check("done_align", 64'(done_cyc), 64'((cfg_row >= cfg_col) ? last_a : last_b));
        check("skew_gap", 64'(last_a - last_b), 64'(cfg_row - cfg_col));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0;
        set_cfg(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_a", m_a, 64'd0);
        check("rst_b", m_b, 64'd0);
        check("rst_vld", 64'({m_av, m_bv}), 64'd0);
        check("rst_done", 64'(m_done), 64'd0);
        check("rst_rdy", 64'(m_rdy), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        in_vld = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_rdy", 64'(m_rdy), 64'd0);
            check("idle_busy", 64'(m_busy), 64'd0);
        end
        in_vld = 1'b0;

        set_cfg(1); load_tile(-1, 0, 1'b0, 1'b1); finish_tile(1'b0);
        set_cfg(2); load_tile(-1, 0, 1'b0, 1'b0); finish_tile(1'b0);
        set_cfg(0); load_tile(0, 5, 1'b0, 1'b0);  finish_tile(1'b0);
        load_tile(-1, 0, 1'b1, 1'b0); finish_tile(1'b1);
        load_tile(-1, 0, 1'b0, 1'b0); finish_tile(1'b0);

        // Abort a tile at t=2 with reset, then run a fresh one.
        set_cfg(1);
        load_tile(-1, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_avld", 64'(m_av), 64'h3);
        rst_n = 1'b0;
        #1;
        check("abort_avld", 64'(m_av), 64'd0);
        check("abort_bvld", 64'(m_bv), 64'd0);
        check("abort_busy", 64'(m_busy), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen), 64'(done_before));
        load_tile(-1, 0, 1'b0, 1'b0); finish_tile(1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
